keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Front-end stage that sits directly upstream of the bank ATM controller.
- Converts raw keypad activity (a 4-bit key code plus a level "key held" signal) into the controller's input handshakes:
  - In PIN mode, one DIGITO/DIGITO_STB pulse per key press.
  - In amount mode, decimal digits accumulate into a 32-bit binary MONTO, committed with MONTO_STB on ENTER.
- Handles edge detection, optional debounce, digit limit, overflow and clear.

Parameters:
MAX_DIGITOS, 10, maximum decimal digits accepted in amount mode; further digits ignored.
DEB_CICLOS, 4, consecutive high samples required before a press is accepted (used only with DEBOUNCE_EN).

Ports:
CLK  input  1  system clock, all logic on rising edge.
RESET  input  1  synchronous, active-high reset.
TECLA  input  4  key code: 0-9 digits, 4'hA CLEAR, 4'hB ENTER, 4'hC-4'hF ignored.
TECLA_PRESIONADA  input  1  level, high while a key is held; TECLA stable while high.
MODO  input  1  0 = PIN mode, 1 = amount mode.
DIGITO  output  4  last accepted digit (PIN mode).
DIGITO_STB  output  1  one-cycle pulse, DIGITO valid.
MONTO  output  32  last committed amount, binary.
MONTO_STB  output  1  one-cycle pulse, MONTO valid.
DESBORDE  output  1  sticky overflow flag for current amount entry.

Behaviour:
- Interface: one clock, CLK; reset RESET is synchronous and active-high. All outputs registered.
- Reset values: DIGITO=0, DIGITO_STB=0, MONTO=0, MONTO_STB=0, DESBORDE=0; internal accumulator=0, digit count=0.
- FSM states:
  - ESPERA: key released, waiting for a press.
  - FILTRO: debounce counting; only with DEBOUNCE_EN.
  - ACEPTADA: press accepted, waiting for release.
- ESPERA -> (ACEPTADA or FILTRO) when TECLA_PRESIONADA is sampled high.
- ACEPTADA -> ESPERA when TECLA_PRESIONADA is sampled low.
- A held key produces exactly one acceptance.
- After reset, if TECLA_PRESIONADA is already high, the FSM enters ACEPTADA without accepting; the key must be released first.
- Latency: a press accepted at edge N drives its strobe high from edge N+1 to edge N+2 (exactly one cycle). Strobes never overlap; at most one strobe per press.
- PIN mode (MODO=0):
  - Digit 0-9: DIGITO <= TECLA, pulse DIGITO_STB.
  - CLEAR, ENTER and codes C-F: no effect.
  - DIGITO holds its value until the next accepted digit.
- Amount mode (MODO=1):
  - Digit d: if count < MAX_DIGITOS and acc*10+d <= 32'hFFFF_FFFF, then acc <= acc*10+d and count++. Compute in 36 bits and compare.
  - If the digit would overflow: acc unchanged, DESBORDE <= 1.
  - If count == MAX_DIGITOS: digit ignored, no flag.
  - ENTER with count > 0: MONTO <= acc, pulse MONTO_STB, then acc=0, count=0, DESBORDE=0.
  - ENTER with count == 0: ignored, no strobe.
  - CLEAR: acc=0, count=0, DESBORDE=0. MONTO unchanged. No strobe.
  - No DIGITO_STB in amount mode.
- MODO change: any sampled change clears acc, count and DESBORDE in the same cycle. A press accepted in that cycle uses the new mode with a cleared accumulator.
- RESET asserted mid-press or mid-entry: all state and outputs return to reset values on that edge, including cancelling a pending strobe.
- Codes C-F: accepted for edge purposes (consume the press), no other effect.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined:
  - ESPERA -> FILTRO on a high sample; the counter counts consecutive high samples.
  - On reaching DEB_CICLOS: accept and go to ACEPTADA, with the strobe on the following cycle.
  - Any low sample in FILTRO: return to ESPERA, counter cleared, nothing accepted.
  - Latency from first high sample to strobe is DEB_CICLOS+1 cycles.
- Not defined: no FILTRO state and no counter; the first high sample is accepted immediately (strobe one cycle later).

Test Plan:
- PIN mode, press/release keys 8,5,5,1, each held 3 cycles -> four single-cycle DIGITO_STB pulses with DIGITO=8,5,5,1; PIN formed downstream = 16'h8551.
- Amount mode, keys 1,2,8 then ENTER -> MONTO=128 (32'h80), one MONTO_STB pulse; a second ENTER -> no strobe.
- Amount mode, digits 4,2,9,4,9,6,7,2,9,5 then ENTER -> MONTO=32'hFFFF_FFFF, DESBORDE=0. Same sequence ending in 6 -> DESBORDE=1, then ENTER commits 429496729, DESBORDE cleared.
- Amount mode, 11 digits '1', then ENTER -> MONTO=1111111111 (11th ignored); CLEAR mid-entry then 5, ENTER -> MONTO=5.
- Key held 20 cycles -> exactly one strobe. RESET asserted while held -> outputs 0; no strobe until release and re-press.
- With DEBOUNCE_EN, DEB_CICLOS=4: 3-cycle glitch -> no strobe; 5-cycle press -> strobe 5 cycles after first high sample.

Source files
------------

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: keypad-side inputs and ATM-controller-side outputs.
// master = keypad/bench driver, slave = keypad_entry.
interface keypad_entry_if;
  logic [3:0]  TECLA;
  logic        TECLA_PRESIONADA;
  logic        MODO;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic [31:0] MONTO;
  logic        MONTO_STB;
  logic        DESBORDE;

  modport master (
    output TECLA, TECLA_PRESIONADA, MODO,
    input  DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
  );

  modport slave (
    input  TECLA, TECLA_PRESIONADA, MODO,
    output DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
  );
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry: keypad press -> PIN digit strobes or binary amount entry.
// Ports: CLK, RESET (sync, active-high), kp (keypad_entry_if.slave).
//   kp in : TECLA, TECLA_PRESIONADA, MODO
//   kp out: DIGITO/DIGITO_STB, MONTO/MONTO_STB, DESBORDE
// Optional: define DEBOUNCE_EN to add the FILTRO state (DEB_CICLOS).
module keypad_entry #(
  parameter int MAX_DIGITOS = 10
`ifdef DEBOUNCE_EN
  , parameter int DEB_CICLOS = 4
`endif
) (
  input  logic          CLK,
  input  logic          RESET,
  keypad_entry_if.slave kp
);

  localparam int CW = $clog2(MAX_DIGITOS + 1);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    ACEPTADA = 2'd1
`ifdef DEBOUNCE_EN
    , FILTRO = 2'd2
`endif
  } st_t;

  st_t  st_q, st_d;
  logic fresh_q;
  logic acepta;
  logic pres;

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CICLOS + 1);
  logic [DW-1:0] deb_q, deb_d;
`endif

  assign pres = kp.TECLA_PRESIONADA;

  // FSM state register; fresh_q marks the first sample after reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q    <= ESPERA;
      fresh_q <= 1'b1;
`ifdef DEBOUNCE_EN
      deb_q   <= '0;
`endif
    end else begin
      st_q    <= st_d;
      fresh_q <= 1'b0;
`ifdef DEBOUNCE_EN
      deb_q   <= deb_d;
`endif
    end
  end

  // FSM next state
  always_comb begin
    st_d = st_q;
`ifdef DEBOUNCE_EN
    deb_d = '0;
`endif
    case (st_q)
      ESPERA: begin
        if (pres) begin
          // a key already held across reset must be released first
          if (fresh_q) begin
            st_d = ACEPTADA;
          end else begin
`ifdef DEBOUNCE_EN
            st_d = FILTRO;
`else
            st_d = ACEPTADA;
`endif
          end
        end
      end
`ifdef DEBOUNCE_EN
      FILTRO: begin
        if (!pres) begin
          st_d = ESPERA;
        end else if (deb_q == DW'(DEB_CICLOS - 1)) begin
          st_d = ACEPTADA;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
`endif
      ACEPTADA: begin
        if (!pres) st_d = ESPERA;
      end
      default: st_d = ESPERA;
    endcase
  end

  // FSM output: one acceptance pulse per press
  always_comb begin
`ifdef DEBOUNCE_EN
    acepta = (st_q == FILTRO) && pres &&
             (deb_q == DW'(DEB_CICLOS - 1));
`else
    acepta = (st_q == ESPERA) && pres && !fresh_q;
`endif
  end

  // accepted key is registered, then processed one edge later
  logic          pend_q;
  logic [3:0]    tec_q;
  logic          modo_q;
  logic [31:0]   acc_q, acc_d, acc_b;
  logic [CW-1:0] ndig_q, ndig_d, ndig_b;
  logic          ovf_q, ovf_d, ovf_b;
  logic [31:0]   monto_q, monto_d;
  logic          mstb_q, mstb_d;
  logic [3:0]    dig_q, dig_d;
  logic          dstb_q, dstb_d;
  logic          mchg;
  logic          es_dig;
  logic [35:0]   prod;

  always_comb begin
    mchg    = kp.MODO != modo_q;
    acc_b   = mchg ? '0 : acc_q;
    ndig_b  = mchg ? '0 : ndig_q;
    ovf_b   = mchg ? 1'b0 : ovf_q;
    acc_d   = acc_b;
    ndig_d  = ndig_b;
    ovf_d   = ovf_b;
    monto_d = monto_q;
    mstb_d  = 1'b0;
    dig_d   = dig_q;
    dstb_d  = 1'b0;
    es_dig  = tec_q <= 4'd9;
    // 36 bits so the overflow shows up in the top nibble
    prod    = {4'd0, acc_b} * 36'd10 + {32'd0, tec_q};
    if (pend_q) begin
      if (!kp.MODO) begin
        if (es_dig) begin
          dig_d  = tec_q;
          dstb_d = 1'b1;
        end
      end else begin
        unique case (1'b1)
          es_dig: begin
            if (ndig_b < CW'(MAX_DIGITOS)) begin
              if (prod[35:32] == 4'd0) begin
                acc_d  = prod[31:0];
                ndig_d = ndig_b + CW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
          tec_q == 4'hB: begin
            if (ndig_b != '0) begin
              monto_d = acc_b;
              mstb_d  = 1'b1;
              acc_d   = '0;
              ndig_d  = '0;
              ovf_d   = 1'b0;
            end
          end
          tec_q == 4'hA: begin
            acc_d  = '0;
            ndig_d = '0;
            ovf_d  = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q  <= 1'b0;
      tec_q   <= '0;
      modo_q  <= 1'b0;
      acc_q   <= '0;
      ndig_q  <= '0;
      ovf_q   <= 1'b0;
      monto_q <= '0;
      mstb_q  <= 1'b0;
      dig_q   <= '0;
      dstb_q  <= 1'b0;
    end else begin
      pend_q  <= acepta;
      if (acepta) tec_q <= kp.TECLA;
      modo_q  <= kp.MODO;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      ovf_q   <= ovf_d;
      monto_q <= monto_d;
      mstb_q  <= mstb_d;
      dig_q   <= dig_d;
      dstb_q  <= dstb_d;
    end
  end

  assign kp.DIGITO     = dig_q;
  assign kp.DIGITO_STB = dstb_q;
  assign kp.MONTO      = monto_q;
  assign kp.MONTO_STB  = mstb_q;
  assign kp.DESBORDE   = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: scoreboard bench for keypad_entry.
// Expected strobes are queued at press time and popped on strobe.
module tb_keypad_entry;

  localparam int DEB = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT = DEB;
`else
  localparam int LAT = 0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  keypad_entry_if kp();

  keypad_entry dut (
    .CLK   (CLK),
    .RESET (RESET),
    .kp    (kp)
  );

  typedef struct {
    bit          m;
    logic [31:0] v;
    int          at;
  } ev_t;

  ev_t         sb[$];
  int          cyc = 0;
  int          nvec = 0;
  int          nbad = 0;
  logic [15:0] pin_sr = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET && (kp.DIGITO_STB || kp.MONTO_STB)) begin
      ev_t e;
      if (kp.DIGITO_STB && kp.MONTO_STB) chk("overlap", 1, 0);
      if (kp.DIGITO_STB) pin_sr = {pin_sr[11:0], kp.DIGITO};
      if (sb.size() == 0) begin
        chk("spurious_stb", {30'd0, kp.DIGITO_STB, kp.MONTO_STB}, 0);
      end else begin
        e = sb.pop_front();
        chk("stb_kind", {31'd0, kp.MONTO_STB}, {31'd0, e.m});
        chk("stb_val", e.m ? kp.MONTO : {28'd0, kp.DIGITO}, e.v);
        chk("stb_lat", cyc, e.at);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(logic [3:0] k, int hold, bit expd,
                       bit em, logic [31:0] ev);
    kp.TECLA = k;
    kp.TECLA_PRESIONADA = 1'b1;
    if (expd) sb.push_back('{em, ev, cyc + 2 + LAT});
    tick(hold + LAT);
    kp.TECLA_PRESIONADA = 1'b0;
    tick(2);
  endtask

  task automatic pin(logic [3:0] k);
    press(k, 3, k <= 4'd9, 1'b0, {28'd0, k});
  endtask

  task automatic amt(string s);
    for (int i = 0; i < s.len(); i++)
      press(4'(s[i] - 8'd48), 3, 1'b0, 1'b0, '0);
  endtask

  task automatic enter(bit expd, logic [31:0] ev);
    press(4'hB, 3, expd, 1'b1, ev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    kp.TECLA = '0;
    kp.TECLA_PRESIONADA = 1'b0;
    kp.MODO = 1'b0;
    RESET = 1'b1;
    tick(3);
    chk("rst_digito", {28'd0, kp.DIGITO}, 0);
    chk("rst_dstb", {31'd0, kp.DIGITO_STB}, 0);
    chk("rst_monto", kp.MONTO, 0);
    chk("rst_mstb", {31'd0, kp.MONTO_STB}, 0);
    chk("rst_desborde", {31'd0, kp.DESBORDE}, 0);
    RESET = 1'b0;
    tick(2);

    pin(4'd8); pin(4'd5); pin(4'd5); pin(4'd1);
    chk("pin_8551", {16'd0, pin_sr}, 32'h8551);
    pin(4'hA); pin(4'hB); pin(4'hC); pin(4'hF);
    chk("pin_hold", {28'd0, kp.DIGITO}, 1);

    kp.MODO = 1'b1;
    tick(2);
    amt("128");
    enter(1'b1, 32'h80);
    enter(1'b0, '0);
    chk("monto_kept", kp.MONTO, 32'h80);

    amt("4294967295");
    chk("max_noflag", {31'd0, kp.DESBORDE}, 0);
    enter(1'b1, 32'hFFFF_FFFF);

    amt("4294967296");
    chk("ovf_flag", {31'd0, kp.DESBORDE}, 1);
    enter(1'b1, 32'd429496729);
    chk("ovf_clr", {31'd0, kp.DESBORDE}, 0);

    amt("11111111111");
    chk("limit_noflag", {31'd0, kp.DESBORDE}, 0);
    enter(1'b1, 32'd1111111111);

    amt("12");
    press(4'hA, 3, 1'b0, 1'b0, '0);
    amt("5");
    enter(1'b1, 32'd5);

    amt("7");
    kp.MODO = 1'b0;
    tick(2);
    pin(4'd9);
    kp.MODO = 1'b1;
    tick(2);
    amt("3");
    enter(1'b1, 32'd3);

    amt("4294967296");
    chk("ovf_flag2", {31'd0, kp.DESBORDE}, 1);
    kp.MODO = 1'b0;
    tick(2);
    chk("modo_clr", {31'd0, kp.DESBORDE}, 0);

    press(4'd4, 20, 1'b1, 1'b0, 32'd4);

    kp.TECLA = 4'd7;
    kp.TECLA_PRESIONADA = 1'b1;
    tick(1 + LAT);
    RESET = 1'b1;
    tick(1);
    chk("rstp_digito", {28'd0, kp.DIGITO}, 0);
    chk("rstp_dstb", {31'd0, kp.DIGITO_STB}, 0);
    chk("rstp_monto", kp.MONTO, 0);
    tick(2);
    RESET = 1'b0;
    tick(6 + LAT);
    kp.TECLA_PRESIONADA = 1'b0;
    tick(2);
    pin(4'd2);

`ifdef DEBOUNCE_EN
    kp.TECLA = 4'd6;
    kp.TECLA_PRESIONADA = 1'b1;
    tick(3);
    kp.TECLA_PRESIONADA = 1'b0;
    tick(6);
    kp.TECLA_PRESIONADA = 1'b1;
    sb.push_back('{1'b0, 32'd6, cyc + 2 + DEB});
    tick(5);
    kp.TECLA_PRESIONADA = 1'b0;
    tick(3);
`endif

    tick(5);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
